// File: rtl/slave_mode_sequencer.sv
// Slave-mode sequencer: synchronises trgi, detects edges, optionally delays
// them, and drives counter reset/enable/start plus the sticky TIF flag.
module slave_mode_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int MSM_DELAY   = 1
) (
    input  logic       clk_i,
    input  logic       aresetn_i,
    input  logic [2:0] sms_i,
    input  logic       msm_i,
    input  logic       trgi_i,
    input  logic       cen_i,
    input  logic       tif_clr_i,
    output logic       cnt_en_o,
    output logic       cnt_rst_o,
    output logic       sm_uev_o,
    output logic       cen_set_o,
    output logic       tif_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RST_MODE  = 3'd1,
        GATE_OPEN = 3'd2,
        GATE_SHUT = 3'd3,
        TRIG_ARM  = 3'd4,
        TRIG_RUN  = 3'd5
    } state_t;

    logic [SYNC_STAGES-1:0]      r_sync;
    logic                        r_trgs_d;
    logic [2:0]                  r_ev;
    logic [MSM_DELAY-1:0][2:0]   r_dly;
    logic [2:0]                  r_sms;
    logic                        r_cen_q;
    state_t                      r_state;
    logic                        r_cnt_en;
    logic                        r_cnt_rst;
    logic                        r_uev;
    logic                        r_cen_set;
    logic                        r_tif;

    state_t     w_next;
    logic       w_trgs;
    logic       w_rise;
    logic       w_fall;
    logic       w_sms_chg;
    logic [2:0] w_mask;
    logic [2:0] w_ev;
    logic       w_set;
    logic       w_rst;
    logic       w_cen_set;
    logic       w_cnt_en;

    assign w_trgs    = r_sync[SYNC_STAGES-1];
    assign w_rise    = w_trgs & ~r_trgs_d;
    assign w_fall    = ~w_trgs & r_trgs_d;
    assign w_sms_chg = (sms_i != r_sms);
    // Event bits are {rise, fall, level}; a mode change drops edges in flight
    // but keeps the level so gated mode picks up the current trigger state.
    assign w_mask    = {~w_sms_chg, ~w_sms_chg, 1'b1};
    assign w_ev      = msm_i ? r_dly[MSM_DELAY-1] : r_ev;

    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            r_sync   <= '0;
            r_trgs_d <= 1'b0;
            r_ev     <= '0;
            r_dly    <= '0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], trgi_i};
            r_trgs_d <= w_trgs;
            r_ev     <= {w_rise, w_fall, w_trgs} & w_mask;
            r_dly[0] <= r_ev & w_mask;
            for (int i = 1; i < MSM_DELAY; i++) begin
                r_dly[i] <= r_dly[i-1] & w_mask;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        w_set     = 1'b0;
        w_rst     = 1'b0;
        w_cen_set = 1'b0;
        if (w_sms_chg) begin
            w_next = IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    unique case (sms_i)
                        3'b100:  w_next = RST_MODE;
                        3'b101:  w_next = w_ev[0] ? GATE_OPEN : GATE_SHUT;
                        3'b110:  w_next = TRIG_ARM;
                        default: w_next = IDLE;
                    endcase
                end
                RST_MODE: begin
                    w_rst = w_ev[2];
                    w_set = w_ev[2];
                end
                GATE_OPEN: begin
                    if (w_ev[1]) begin
                        w_next = GATE_SHUT;
                        w_set  = 1'b1;
                    end
                end
                GATE_SHUT: begin
                    if (w_ev[2]) begin
                        w_next = GATE_OPEN;
                        w_set  = 1'b1;
                    end
                end
                TRIG_ARM: begin
                    if (w_ev[2]) begin
                        w_next    = TRIG_RUN;
                        w_set     = 1'b1;
                        w_cen_set = ~cen_i;
                    end
                end
                TRIG_RUN: begin
                    w_set = w_ev[2];
                    // Leave on a CEN falling edge, not on its level, so the
                    // cycle before software CEN catches up does not disarm.
                    if (r_cen_q && !cen_i) begin
                        w_next = TRIG_ARM;
                    end
                end
                default: w_next = IDLE;
            endcase
        end
    end

    always_comb begin
        w_cnt_en = cen_i;
        unique case (1'b1)
            (sms_i == 3'b101):
                w_cnt_en = cen_i & (w_next == GATE_OPEN);
            (w_next == TRIG_ARM || w_next == TRIG_RUN):
                w_cnt_en = cen_i | w_cen_set;
            default:
                w_cnt_en = cen_i;
        endcase
    end

    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            r_state   <= IDLE;
            r_sms     <= 3'b000;
            r_cen_q   <= 1'b0;
            r_cnt_en  <= 1'b0;
            r_cnt_rst <= 1'b0;
            r_uev     <= 1'b0;
            r_cen_set <= 1'b0;
            r_tif     <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_sms     <= sms_i;
            r_cen_q   <= cen_i;
            r_cnt_en  <= w_cnt_en;
            r_cnt_rst <= w_rst;
            r_uev     <= w_rst;
            r_cen_set <= w_cen_set;
            r_tif     <= w_set | (r_tif & ~tif_clr_i);
        end
    end

    assign cnt_en_o  = r_cnt_en;
    assign cnt_rst_o = r_cnt_rst;
    assign sm_uev_o  = r_uev;
    assign cen_set_o = r_cen_set;
    assign tif_o     = r_tif;
    assign state_o   = r_state;

endmodule

// File: tb/tb_slave_mode_sequencer.sv
// Bench for slave_mode_sequencer: directed scenarios plus random traffic,
// all compared cycle by cycle against a sampled-history reference model.
module tb_slave_mode_sequencer;

    localparam int SYNC = 2;
    localparam int DLY  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] sms = 3'b000;
    logic       msm = 1'b0;
    logic       trgi = 1'b0;
    logic       cen = 1'b0;
    logic       clr = 1'b0;
    logic       cnt_en, cnt_rst, uev, cen_set, tif;
    logic [2:0] st;

    slave_mode_sequencer #(.SYNC_STAGES(SYNC), .MSM_DELAY(DLY)) dut (
        .clk_i(clk), .aresetn_i(rst_n), .sms_i(sms), .msm_i(msm),
        .trgi_i(trgi), .cen_i(cen), .tif_clr_i(clr),
        .cnt_en_o(cnt_en), .cnt_rst_o(cnt_rst), .sm_uev_o(uev),
        .cen_set_o(cen_set), .tif_o(tif), .state_o(st)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int n;
    bit smp_h [4096];
    int sms_h [4096];
    bit cen_h [4096];
    int m_st;
    bit m_tif;
    bit e_en, e_rst, e_cs;
    int e_st;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s edge=%0d got=%0d exp=%0d", tag, n, got, exp);
        end
    endtask

    function automatic bit gs(input int k);
        return (k < 1) ? 1'b0 : smp_h[k];
    endfunction

    function automatic int gm(input int k);
        return (k < 1) ? 0 : sms_h[k];
    endfunction

    function automatic bit gc(input int k);
        return (k < 1) ? 1'b0 : cen_h[k];
    endfunction

    // One clock edge of the reference: the trigger event seen at edge n is
    // the sampled trgi from L edges earlier; it is void if sms moved while
    // it was in flight.
    task automatic model_edge();
        int d, lat, nx;
        bit a, b, r, f, stable, chg, set, cs;
        n++;
        smp_h[n] = trgi;
        sms_h[n] = int'(sms);
        cen_h[n] = cen;
        d   = msm ? DLY : 0;
        lat = SYNC + 1 + d;
        a = gs(n - lat);
        b = gs(n - lat - 1);
        r = a & ~b;
        f = ~a & b;
        stable = 1'b1;
        for (int k = n - 2 - d; k < n; k++)
            if (gm(k) != gm(n)) stable = 1'b0;
        if (!stable) begin
            r = 1'b0;
            f = 1'b0;
        end
        chg = (gm(n) != gm(n - 1));
        nx = m_st;
        set = 1'b0;
        cs = 1'b0;
        e_rst = 1'b0;
        if (chg) nx = 0;
        else if (m_st == 0) begin
            if (gm(n) == 4) nx = 1;
            else if (gm(n) == 5) nx = a ? 2 : 3;
            else if (gm(n) == 6) nx = 4;
        end else if (m_st == 1) begin
            e_rst = r;
            set = r;
        end else if (m_st == 2 && f) begin
            nx = 3;
            set = 1'b1;
        end else if (m_st == 3 && r) begin
            nx = 2;
            set = 1'b1;
        end else if (m_st == 4 && r) begin
            nx = 5;
            set = 1'b1;
            cs = ~cen;
        end else if (m_st == 5) begin
            set = r;
            if (gc(n - 1) && !gc(n)) nx = 4;
        end
        if (gm(n) == 5) e_en = cen && (nx == 2);
        else if (nx == 4 || nx == 5) e_en = cen | cs;
        else e_en = cen;
        e_cs = cs;
        m_st = nx;
        e_st = nx;
        m_tif = set | (m_tif & ~clr);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("cnt_en", int'(cnt_en), int'(e_en));
        chk("cnt_rst", int'(cnt_rst), int'(e_rst));
        chk("sm_uev", int'(uev), int'(e_rst));
        chk("cen_set", int'(cen_set), int'(e_cs));
        chk("tif", int'(tif), int'(m_tif));
        chk("state", int'(st), e_st);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        chk("rst_en", int'(cnt_en), 0);
        chk("rst_cnt_rst", int'(cnt_rst), 0);
        chk("rst_uev", int'(uev), 0);
        chk("rst_cen_set", int'(cen_set), 0);
        chk("rst_tif", int'(tif), 0);
        chk("rst_state", int'(st), 0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        m_st = 0;
        m_tif = 1'b0;
    endtask

    initial begin
        n = 0;
        m_st = 0;
        m_tif = 1'b0;

        sms = 3'b100; msm = 1'b0; cen = 1'b0; trgi = 1'b0; clr = 1'b0;
        do_reset();
        for (int c = 1; c <= 20; c++) begin
            trgi = (c >= 11);
            tick();
            if (c == 13) chk("t1_rst13", int'(cnt_rst), 0);
            if (c == 14) chk("t1_rst14", int'(cnt_rst), 1);
            if (c == 14) chk("t1_uev14", int'(uev), 1);
            if (c == 15) chk("t1_rst15", int'(cnt_rst), 0);
            if (c == 15) chk("t1_tif15", int'(tif), 1);
        end

        sms = 3'b101; cen = 1'b1; trgi = 1'b0;
        do_reset();
        for (int c = 1; c <= 40; c++) begin
            trgi = (c >= 11 && c <= 30);
            clr = (c == 21 || c == 34);
            tick();
            if (c == 13) chk("t2_en13", int'(cnt_en), 0);
            if (c == 14) chk("t2_en14", int'(cnt_en), 1);
            if (c == 14) chk("t2_tif14", int'(tif), 1);
            if (c == 25) chk("t2_tif25", int'(tif), 0);
            if (c == 33) chk("t2_en33", int'(cnt_en), 1);
            if (c == 34) chk("t2_en34", int'(cnt_en), 0);
            if (c == 34) chk("t2_tif_collide", int'(tif), 1);
        end
        clr = 1'b0;

        sms = 3'b110; cen = 1'b0; trgi = 1'b0;
        do_reset();
        for (int c = 1; c <= 36; c++) begin
            cen = (c >= 15 && c < 32);
            trgi = (c >= 11 && c < 20) || (c >= 25);
            clr = (c == 22);
            tick();
            if (c == 14) chk("t3_cs14", int'(cen_set), 1);
            if (c == 14) chk("t3_en14", int'(cnt_en), 1);
            if (c == 14) chk("t3_st14", int'(st), 5);
            if (c == 28) chk("t3_cs28", int'(cen_set), 0);
            if (c == 28) chk("t3_tif28", int'(tif), 1);
            if (c == 32) chk("t3_st32", int'(st), 4);
        end
        clr = 1'b0;

        sms = 3'b100; msm = 1'b1; cen = 1'b0; trgi = 1'b0;
        do_reset();
        for (int c = 1; c <= 22; c++) begin
            trgi = (c >= 11);
            tick();
            if (c == 14) chk("t4_rst14", int'(cnt_rst), 0);
            if (c == 17) chk("t4_rst17", int'(cnt_rst), 1);
        end
        sms = 3'b100; trgi = 1'b0;
        do_reset();
        for (int c = 1; c <= 24; c++) begin
            trgi = (c >= 11);
            sms = (c >= 16) ? 3'b000 : 3'b100;
            tick();
            if (c == 17) chk("t4_norst17", int'(cnt_rst), 0);
            if (c == 17) chk("t4_st17", int'(st), 0);
            if (c == 24) chk("t4_tif24", int'(tif), 0);
        end

        sms = 3'b101; msm = 1'b0; cen = 1'b1; trgi = 1'b1;
        do_reset();
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 8) chk("t5_en8", int'(cnt_en), 1);
        end
        do_reset();
        tick();
        chk("t5_st_after", int'(st), 0);

        for (int seg = 0; seg < 6; seg++) begin
            msm = seg[0];
            do_reset();
            for (int c = 1; c <= 400; c++) begin
                if ($urandom_range(39) == 0) begin
                    case ($urandom_range(4))
                        0: sms = 3'b000;
                        1: sms = 3'b100;
                        2: sms = 3'b101;
                        3: sms = 3'b110;
                        default: sms = 3'b011;
                    endcase
                end
                if ($urandom_range(5) == 0) trgi = ~trgi;
                if ($urandom_range(19) == 0) cen = ~cen;
                clr = ($urandom_range(14) == 0);
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
